// File: rtl/writeback.sv
// Writeback stage: the last in-order stage after execute.
// It commits register-file writes, keeps the rd-busy scoreboard that decode
// checks before issue, pulses fetch redirects for taken branches and jumps,
// holds a trap until the trap unit acknowledges it, and counts retired
// instructions. Every output is registered and appears one cycle after the
// execute result that caused it.
module writeback #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    res_valid,
    input  logic [XLEN-1:0]         res_pc,
    input  logic                    res_we,
    input  logic [$clog2(NREG)-1:0] res_rd,
    input  logic [XLEN-1:0]         res_wdata,
    input  logic                    res_redirect,
    input  logic [XLEN-1:0]         res_target,
    input  logic                    res_exc,
    input  logic [3:0]              res_cause,
    input  logic                    issue_fire,
    input  logic                    issue_we,
    input  logic [$clog2(NREG)-1:0] issue_rd,
    output logic [NREG-1:0]         busy,
    output logic                    rf_we,
    output logic [$clog2(NREG)-1:0] rf_waddr,
    output logic [XLEN-1:0]         rf_wdata,
    output logic                    redirect_valid,
    output logic [XLEN-1:0]         redirect_pc,
    output logic                    trap_valid,
    output logic [XLEN-1:0]         trap_pc,
    output logic [3:0]              trap_cause,
    input  logic                    trap_ack,
    output logic [CNT_W-1:0]        instret
);

    localparam int RW = $clog2(NREG);

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

    state_t state_reg;

    logic [NREG-1:0] clear_mask;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] busy_next;

    // Build the per-register clear and set masks, then merge them so that a
    // set in the same cycle wins over a clear. x0 is never busy.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
            assign clear_mask[gi] = res_valid && res_we && (res_rd == RW'(gi));
            assign set_mask[gi]   = issue_fire && issue_we && (issue_rd == RW'(gi));
            if (gi == 0) begin : g_x0
                assign busy_next[gi] = 1'b0;
            end else begin : g_xn
                assign busy_next[gi] = (busy[gi] & ~clear_mask[gi]) | set_mask[gi];
            end
        end
    endgenerate

    // The scoreboard follows execute results (committed or squashed), not rf_we.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Commit / trap control: the RUN state retires results; TRAP squashes
    // everything until the trap unit acknowledges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= RUN;
            rf_we          <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            trap_valid     <= 1'b0;
            trap_pc        <= '0;
            trap_cause     <= '0;
            instret        <= '0;
        end else begin
            // Both pulses drop unless re-asserted below.
            rf_we          <= 1'b0;
            redirect_valid <= 1'b0;
            case (state_reg)
                RUN: begin
                    if (res_valid) begin
                        if (res_exc) begin
                            // An exception beats any redirect on the same result.
                            trap_valid <= 1'b1;
                            trap_pc    <= res_pc;
                            trap_cause <= res_cause;
                            state_reg  <= TRAP;
                        end else begin
                            rf_we    <= res_we && (res_rd != '0);
                            rf_waddr <= res_rd;
                            rf_wdata <= res_wdata;
                            instret  <= instret + 1'b1;
                            if (res_redirect) begin
                                redirect_valid <= 1'b1;
                                redirect_pc    <= res_target;
                            end
                        end
                    end
                end
                TRAP: begin
                    // Results here, including in the ack cycle, are dropped.
                    if (trap_ack) begin
                        trap_valid <= 1'b0;
                        state_reg  <= RUN;
                    end
                end
                default: state_reg <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback.sv
// Randomised and directed bench for the writeback stage, checked against a
// behavioural model of the stage's retirement rules.
module tb_writeback;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int CNT_W = 4;
    localparam int RW    = $clog2(NREG);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              res_valid = 1'b0;
    logic [XLEN-1:0]   res_pc = '0;
    logic              res_we = 1'b0;
    logic [RW-1:0]     res_rd = '0;
    logic [XLEN-1:0]   res_wdata = '0;
    logic              res_redirect = 1'b0;
    logic [XLEN-1:0]   res_target = '0;
    logic              res_exc = 1'b0;
    logic [3:0]        res_cause = '0;
    logic              issue_fire = 1'b0;
    logic              issue_we = 1'b0;
    logic [RW-1:0]     issue_rd = '0;
    logic              trap_ack = 1'b0;
    logic [NREG-1:0]   busy;
    logic              rf_we;
    logic [RW-1:0]     rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              trap_valid;
    logic [XLEN-1:0]   trap_pc;
    logic [3:0]        trap_cause;
    logic [CNT_W-1:0]  instret;

    writeback #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_pc(res_pc), .res_we(res_we), .res_rd(res_rd),
        .res_wdata(res_wdata), .res_redirect(res_redirect), .res_target(res_target),
        .res_exc(res_exc), .res_cause(res_cause),
        .issue_fire(issue_fire), .issue_we(issue_we), .issue_rd(issue_rd),
        .busy(busy), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .trap_ack(trap_ack), .instret(instret)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    bit          m_trap;
    bit          m_busy [NREG];
    bit          m_rfwe;
    int unsigned m_waddr;
    int unsigned m_wdata;
    bit          m_rv;
    int unsigned m_rpc;
    int unsigned m_tpc;
    int unsigned m_tcause;
    int unsigned m_instret;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NREG-1:0] model_busy_vec();
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        m_trap = 0; m_rfwe = 0; m_waddr = 0; m_wdata = 0; m_rv = 0; m_rpc = 0;
        m_tpc = 0; m_tcause = 0; m_instret = 0;
        for (int i = 0; i < NREG; i++) m_busy[i] = 0;
    endtask

    // Model: one retirement step per clock from the inputs seen at the edge.
    always @(posedge clk) begin
        if (rst) begin
            m_rfwe = 0;
            m_rv   = 0;
            if (!m_trap) begin
                if (res_valid && res_exc) begin
                    m_trap   = 1;
                    m_tpc    = res_pc;
                    m_tcause = res_cause;
                end else if (res_valid) begin
                    m_rfwe    = res_we && (res_rd != 0);
                    m_waddr   = res_rd;
                    m_wdata   = res_wdata;
                    m_instret = (m_instret + 1) % (1 << CNT_W);
                    if (res_redirect) begin
                        m_rv  = 1;
                        m_rpc = res_target;
                    end
                end
            end else if (trap_ack) begin
                m_trap = 0;
            end
            if (res_valid && res_we) m_busy[res_rd] = 0;
            if (issue_fire && issue_we) m_busy[issue_rd] = 1;
            m_busy[0] = 0;
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(model_busy_vec()));
            chk("rf_we", 64'(rf_we), 64'(m_rfwe));
            chk("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
            chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
            chk("redirect_valid", 64'(redirect_valid), 64'(m_rv));
            chk("redirect_pc", 64'(redirect_pc), 64'(m_rpc));
            chk("trap_valid", 64'(trap_valid), 64'(m_trap));
            chk("trap_pc", 64'(trap_pc), 64'(m_tpc));
            chk("trap_cause", 64'(trap_cause), 64'(m_tcause));
            chk("instret", 64'(instret), 64'(m_instret));
        end
    end

    task automatic idle();
        res_valid = 0; res_we = 0; res_redirect = 0; res_exc = 0;
        issue_fire = 0; issue_we = 0; trap_ack = 0;
    endtask

    // Let the current inputs be captured, then return inputs to idle.
    task automatic step_once();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic drive_res(input logic [XLEN-1:0] pc, input logic we, input logic [RW-1:0] rd,
                             input logic [XLEN-1:0] wd, input logic redir,
                             input logic [XLEN-1:0] tgt, input logic exc, input logic [3:0] cause);
        res_valid = 1; res_pc = pc; res_we = we; res_rd = rd; res_wdata = wd;
        res_redirect = redir; res_target = tgt; res_exc = exc; res_cause = cause;
    endtask

    task automatic drive_issue(input logic [RW-1:0] rd);
        issue_fire = 1; issue_we = 1; issue_rd = rd;
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_instret", 64'(instret), 64'h0);
        chk("reset_trap_valid", 64'(trap_valid), 64'h0);
        @(posedge clk); #1;
        rst = 1;
        chk_en = 1;

        // 1: simple commit
        drive_res(32'h100, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        step_once(); @(negedge clk);
        chk("t1_rf_we", 64'(rf_we), 64'h1);
        chk("t1_rf_waddr", 64'(rf_waddr), 64'h5);
        chk("t1_rf_wdata", 64'(rf_wdata), 64'hDEADBEEF);
        chk("t1_instret", 64'(instret), 64'h1);
        step_once(); @(negedge clk);
        chk("t1_rf_we_drop", 64'(rf_we), 64'h0);

        // 2: scoreboard set/clear
        @(posedge clk); #1;
        drive_issue(7);
        step_once(); @(negedge clk);
        chk("t2_busy7_set", 64'(busy[7]), 64'h1);
        @(posedge clk); #1;
        drive_issue(7);
        drive_res(32'h104, 1, 7, 32'h11, 0, 0, 0, 0);
        step_once(); @(negedge clk);
        chk("t2_busy7_setwins", 64'(busy[7]), 64'h1);
        @(posedge clk); #1;
        drive_res(32'h108, 1, 7, 32'h22, 0, 0, 0, 0);
        step_once(); @(negedge clk);
        chk("t2_busy7_clear", 64'(busy[7]), 64'h0);
        @(posedge clk); #1;
        drive_issue(0);
        step_once(); @(negedge clk);
        chk("t2_busy_x0", 64'(busy), 64'h0);

        // 3: JAL redirect
        @(posedge clk); #1;
        drive_res(32'h10C, 1, 1, 32'h110, 1, 32'h2000, 0, 0);
        step_once(); @(negedge clk);
        chk("t3_redirect_valid", 64'(redirect_valid), 64'h1);
        chk("t3_redirect_pc", 64'(redirect_pc), 64'h2000);
        chk("t3_rf_we", 64'(rf_we), 64'h1);
        chk("t3_instret", 64'(instret), 64'h4);
        step_once(); @(negedge clk);
        chk("t3_redirect_drop", 64'(redirect_valid), 64'h0);

        // 4: exception, squash in TRAP, ack
        @(posedge clk); #1;
        drive_issue(3);
        step_once(); @(negedge clk);
        chk("t4_busy3_set", 64'(busy[3]), 64'h1);
        @(posedge clk); #1;
        drive_res(32'h40, 1, 3, 32'h99, 1, 32'h3000, 1, 2);
        step_once(); @(negedge clk);
        chk("t4_trap_valid", 64'(trap_valid), 64'h1);
        chk("t4_trap_pc", 64'(trap_pc), 64'h40);
        chk("t4_trap_cause", 64'(trap_cause), 64'h2);
        chk("t4_rf_we", 64'(rf_we), 64'h0);
        chk("t4_redirect", 64'(redirect_valid), 64'h0);
        chk("t4_instret", 64'(instret), 64'h4);
        chk("t4_busy3_clear", 64'(busy[3]), 64'h0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            drive_res(32'h44 + 4 * k, 1, 9, 32'h55, 1, 32'h4000, 0, 0);
            step_once(); @(negedge clk);
            chk("t4_squash_rf_we", 64'(rf_we), 64'h0);
            chk("t4_squash_redirect", 64'(redirect_valid), 64'h0);
            chk("t4_squash_instret", 64'(instret), 64'h4);
        end
        @(posedge clk); #1;
        trap_ack = 1;
        drive_res(32'h50, 1, 9, 32'h66, 0, 0, 0, 0);
        step_once(); @(negedge clk);
        chk("t4_ack_trap_valid", 64'(trap_valid), 64'h0);
        chk("t4_ack_squash", 64'(rf_we), 64'h0);
        @(posedge clk); #1;
        drive_res(32'h54, 1, 9, 32'h77, 0, 0, 0, 0);
        step_once(); @(negedge clk);
        chk("t4_resume_rf_we", 64'(rf_we), 64'h1);
        chk("t4_resume_instret", 64'(instret), 64'h5);

        // 5: instret wrap with a 4-bit counter
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            drive_res(32'h200 + 4 * k, 0, 0, 0, 0, 0, 0, 0);
            step_once();
        end
        @(negedge clk);
        chk("t5_instret_15", 64'(instret), 64'hF);
        @(posedge clk); #1;
        drive_res(32'h300, 1, 0, 32'h1, 0, 0, 0, 0);
        step_once(); @(negedge clk);
        chk("t5_instret_wrap", 64'(instret), 64'h0);
        chk("t5_rd0_no_write", 64'(rf_we), 64'h0);

        // Random phase
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            res_valid    = ($urandom_range(0, 9) < 7);
            res_pc       = $urandom;
            res_we       = ($urandom_range(0, 3) != 0);
            res_rd       = RW'($urandom_range(0, NREG - 1));
            res_wdata    = $urandom;
            res_redirect = ($urandom_range(0, 4) == 0);
            res_target   = $urandom;
            res_exc      = ($urandom_range(0, 19) == 0);
            res_cause    = 4'($urandom);
            issue_fire   = ($urandom_range(0, 1) == 1);
            issue_we     = ($urandom_range(0, 3) != 0);
            issue_rd     = RW'($urandom_range(0, NREG - 1));
            trap_ack     = ($urandom_range(0, 2) == 0);
        end
        @(posedge clk); #1;
        idle();

        // 6: asynchronous reset while trapped with x1..x7 busy
        rst = 0;
        model_reset();
        @(posedge clk); #1;
        rst = 1;
        for (int r = 1; r < 8; r++) begin
            drive_issue(RW'(r));
            step_once();
        end
        drive_res(32'h80, 0, 0, 0, 0, 0, 1, 5);
        step_once(); @(negedge clk);
        chk("t6_pre_busy", 64'(busy), 64'hFE);
        chk("t6_pre_trap", 64'(trap_valid), 64'h1);
        #2;
        rst = 0;
        model_reset();
        #1;
        chk("t6_async_busy", 64'(busy), 64'h0);
        chk("t6_async_trap_valid", 64'(trap_valid), 64'h0);
        chk("t6_async_trap_pc", 64'(trap_pc), 64'h0);
        chk("t6_async_trap_cause", 64'(trap_cause), 64'h0);
        chk("t6_async_rf_waddr", 64'(rf_waddr), 64'h0);
        chk("t6_async_instret", 64'(instret), 64'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback.md
Name: writeback

Overview:
- Final in-order stage directly downstream of execute; consumes one execute result per cycle.
- Execute results cannot be back-pressured.
- Commits register-file writes and maintains the rd busy scoreboard that decode consults before issue.
- Raises fetch redirects on taken branches/jumps, holds traps until the trap unit acknowledges, and counts retired instructions.

Parameters:
XLEN, 32, data/address width
NREG, 32, architectural register count (index width = $clog2(NREG))
CNT_W, 64, width of retired-instruction counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
res_valid  in  1  execute result present this cycle (no ready; always accepted)
res_pc  in  XLEN  PC of the instruction
res_we  in  1  instruction writes rd
res_rd  in  $clog2(NREG)  destination register
res_wdata  in  XLEN  rd write value
res_redirect  in  1  taken branch/jump
res_target  in  XLEN  redirect target
res_exc  in  1  instruction raised exception
res_cause  in  4  exception cause
issue_fire  in  1  decode->execute handshake completed this cycle
issue_we  in  1  issued instruction writes rd
issue_rd  in  $clog2(NREG)  issued rd
busy  out  NREG  scoreboard bitmask; bit i set = write to xi pending
rf_we  out  1  register-file write enable
rf_waddr  out  $clog2(NREG)  write address
rf_wdata  out  XLEN  write data
redirect_valid  out  1  one-cycle fetch redirect pulse
redirect_pc  out  XLEN  redirect target
trap_valid  out  1  trap pending
trap_pc  out  XLEN  faulting PC
trap_cause  out  4  cause
trap_ack  in  1  trap unit accepted trap
instret  out  CNT_W  retired count

Behaviour:
- Reset (rst low, async): busy=0, rf_we=0, rf_waddr=0, rf_wdata=0, redirect_valid=0, redirect_pc=0, trap_valid=0, trap_pc=0, trap_cause=0, instret=0, state=RUN.
- All outputs are registered. Latency is 1 cycle from res_valid to rf_we / redirect_valid / trap_valid.
- FSM states: RUN, TRAP.
- RUN, res_valid && !res_exc:
  - rf_we <= res_we && res_rd!=0; rf_waddr/rf_wdata latched.
  - instret += 1.
  - If res_redirect: redirect_valid <= 1, redirect_pc <= res_target.
  - Stay in RUN.
- RUN, res_valid && res_exc:
  - No rf write, no instret increment, no redirect.
  - trap_valid <= 1; trap_pc <= res_pc; trap_cause <= res_cause; go to TRAP.
  - res_exc has priority over res_redirect.
- TRAP:
  - trap_valid stays 1; trap_pc/trap_cause stable.
  - Any res_valid arriving is squashed: no rf write, no redirect, no instret.
  - On trap_ack: trap_valid <= 0, go to RUN next cycle. A result in the ack cycle is still squashed.
- redirect_valid and rf_we are single-cycle pulses, cleared every cycle they are not re-asserted.
- Scoreboard, evaluated each cycle:
  - clear_mask = bit res_rd if res_valid && res_we (committed or squashed).
  - set_mask = bit issue_rd if issue_fire && issue_we.
  - busy <= (busy & ~clear_mask) | set_mask.
  - Same register set and cleared in one cycle: set wins.
  - Bit 0 is forced to 0 always.
- Scoreboard updates at the res_valid cycle, not the rf_we cycle. Decode must therefore also bypass from rf_w* for one cycle; that bypass is decode's job.
- instret wraps modulo 2^CNT_W, no saturation.
- res_rd==0 with res_we: counts as retired, no write, no busy change.
- Reset mid-TRAP or mid-pulse: all state returns to reset values asynchronously.

Test Plan:
1. Reset, then res_valid with pc=0x100, we=1, rd=5, wdata=0xDEADBEEF -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, instret=1; following cycle rf_we=0.
2. issue_fire we=1 rd=7 -> busy[7]=1. Later, res_valid rd=7 and issue_fire rd=7 in the same cycle -> busy[7] stays 1. Next res rd=7 alone -> busy[7]=0. issue rd=0 -> busy=0.
3. res_valid redirect=1, target=0x2000, we=1, rd=1 (JAL) -> next cycle redirect_valid=1, redirect_pc=0x2000, rf_we=1, instret+1; one cycle later redirect_valid=0.
4. res_valid exc=1, cause=2, pc=0x40, redirect=1, we=1, rd=3 (busy[3]=1) -> trap_valid=1, trap_pc=0x40, trap_cause=2; no rf_we, no redirect, instret unchanged, busy[3]=0. Two more results during TRAP -> no writes. trap_ack -> trap_valid=0 next cycle; the next result commits normally.
5. Preload instret near all-ones (CNT_W=4 build, 15 commits) -> 16th commit gives instret=0.
6. Assert rst low asynchronously while trap_valid=1, busy=0xFE -> all outputs 0 immediately, without a clock edge.
